core_scheduler: RTL

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/core_scheduler.sv
`default_nettype none
// ============================================================================
// core_scheduler -- sequences parallel key-search cores and latches the winner
// Revision: 1.0
// ============================================================================
module core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    read_rom_done,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [24*NUM_CORES-1:0] core_key,
  output logic                    core_reset,
  output logic [NUM_CORES-1:0]    start_core,
  output logic [NUM_CORES-1:0]    stop_core,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [IDX_W-1:0]        winner_idx,
  output logic [23:0]             secret_key,
  output logic [31:0]             cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_LAUNCH    = 3'd3,
    S_RUN       = 3'd4,
    S_FOUND     = 3'd5,
    S_EXHAUSTED = 3'd6
  } state_t;

  state_t     state;
  logic       clear_cnt;
  logic       hit_any;
  logic       all_done;
  logic [IDX_W-1:0] hit_idx;
  logic [23:0]      hit_key;

  // Scan from the top down so the lowest-numbered finder wins.
  always_comb begin
    hit_any  = |core_found;
    all_done = &core_done;
    hit_idx  = '0;
    hit_key  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        hit_idx = IDX_W'(i);
        hit_key = core_key[24*i +: 24];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      clear_cnt   <= 1'b0;
      core_reset  <= 1'b0;
      start_core  <= '0;
      stop_core   <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      winner_idx  <= '0;
      secret_key  <= '0;
      cycle_count <= '0;
    end else begin
      start_core <= '0;
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state       <= S_CLEAR;
            clear_cnt   <= 1'b0;
            core_reset  <= 1'b1;
            stop_core   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            found       <= 1'b0;
            winner_idx  <= '0;
            secret_key  <= '0;
            cycle_count <= '0;
          end
        end

        S_CLEAR: begin
          if (abort) begin
            state      <= S_IDLE;
            core_reset <= 1'b0;
            stop_core  <= '1;
            busy       <= 1'b0;
          end else if (clear_cnt) begin
            state      <= S_WAIT_ROM;
            core_reset <= 1'b0;
          end else begin
            clear_cnt  <= 1'b1;
          end
        end

        S_WAIT_ROM: begin
          if (abort) begin
            state     <= S_IDLE;
            stop_core <= '1;
            busy      <= 1'b0;
          end else if (read_rom_done) begin
            state      <= S_LAUNCH;
            start_core <= '1;
          end
        end

        S_LAUNCH: begin
          if (abort) begin
            state     <= S_IDLE;
            stop_core <= '1;
            busy      <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (cycle_count != 32'hFFFF_FFFF)
            cycle_count <= cycle_count + 32'd1;
          // Abort outranks a find, which outranks exhaustion.
          if (abort) begin
            state     <= S_IDLE;
            stop_core <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
          end else if (hit_any) begin
            state      <= S_FOUND;
            stop_core  <= '1;
            busy       <= 1'b0;
            done       <= 1'b1;
            found      <= 1'b1;
            winner_idx <= hit_idx;
            secret_key <= hit_key;
          end else if (all_done) begin
            state     <= S_EXHAUSTED;
            stop_core <= '1;
            busy      <= 1'b0;
            done      <= 1'b1;
            found     <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          core_reset <= 1'b0;
          stop_core  <= '1;
          busy       <= 1'b0;
          done       <= 1'b0;
          found      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
